// File: rtl/cla_word_seq.sv
// Multi-word add/sub sequencer: one CLA_16bit time-shared over WORDS 16-bit slices, LSW first.
// Optional subtract support is enabled by defining CLA_SEQ_SUB_EN.

module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g, p;
  logic [15:0] c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    gc[0] = cin;
    for (int unsigned k = 0; k < 4; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    // Group carries come from lookahead; bit carries only ripple inside a 4-bit group.
    for (int unsigned i = 0; i < 16; i++) begin
      if ((i % 4) == 0) c[i] = gc[i/4];
      else              c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    sum  = p ^ c;
    cout = gc[4];
  end
endmodule

module cla_word_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   op_a,
  input  logic [16*WORDS-1:0]   op_b,
  input  logic                  op_cin,
  input  logic                  op_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          sub_q, sub_d;
  logic          cout_q, cout_d, ovf_q, ovf_d;

  logic [15:0]   cla_a, cla_b, cla_sum;
  logic          cla_cout;
  logic          acc_sub;

`ifdef CLA_SEQ_SUB_EN
  assign acc_sub = op_sub;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign acc_sub       = 1'b0;
`endif

  assign cla_a = a_q[idx_q*16 +: 16];
  assign cla_b = b_q[idx_q*16 +: 16] ^ {16{sub_q}};

  CLA_16bit u_cla (cla_a, cla_b, carry_q, cla_sum, cla_cout);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = acc_sub;
          carry_d = acc_sub ? 1'b1 : op_cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[idx_q*16 +: 16] = cla_sum;
        carry_d = cla_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = cla_cout;
          // Carry into the MSB recovered from the sum bit and its operands.
          ovf_d   = (cla_sum[15] ^ cla_a[15] ^ cla_b[15]) ^ cla_cout;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) & ~rst;
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_word_seq.sv
// Scoreboard bench for cla_word_seq (WORDS=4): driver pushes reference results, monitor pops on handshake.
module tb_cla_word_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;
`ifdef CLA_SEQ_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  cla_word_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int acc_cyc = -100;
  int hs_cyc  = -100;
  int stall   = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
    vectors++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Reference: plain wide arithmetic; signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t r;
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         ci;
    if (SUB_EN && sub) begin bb = ~b; ci = 1'b1; end
    else               begin bb = b;  ci = cin;  end
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
    r.s = full[W-1:0];
    r.c = full[W];
    r.v = (a[W-1] == bb[W-1]) && (r.s[W-1] != a[W-1]);
    return r;
  endfunction

  // Monitor: owns out_ready, checks latency, hold stability and popped results.
  logic         prev_ov = 1'b0;
  logic         prev_or = 1'b0;
  logic [W-1:0] prev_sum = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov   = 1'b0;
      prev_or   = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (out_valid && !prev_ov) chk("latency", 128'(cyc - acc_cyc), 128'(WORDS));
      if (out_valid) chk("in_ready_busy", {127'b0, in_ready}, 128'd0);
      if (out_valid && prev_ov && !prev_or) chk("hold_sum", {64'b0, sum}, {64'b0, prev_sum});
      if (out_valid && stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none", sum);
        end else begin
          e = sb.pop_front();
          chk("sum",  {64'b0, sum},       {64'b0, e.s});
          chk("cout", {127'b0, cout},     {127'b0, e.c});
          chk("ovf",  {127'b0, ovf},      {127'b0, e.v});
        end
        hs_cyc = cyc;
      end
      prev_ov  = out_valid;
      prev_or  = out_ready;
      prev_sum = sum;
    end
    cyc++;
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    int n;
    n = 0;
    @(negedge clk);
    op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 300 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc_cyc = cyc;
    sb.push_back(model(a, b, cin, sub));
    #1;
    in_valid = 1'b0;
    op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    op_cin = 1'($urandom); op_sub = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_sum",       {64'b0, sum},        128'd0);
    chk("rst_cout_ovf",  {126'b0, cout, ovf}, 128'd0);
    chk("rst_in_ready",  {127'b0, in_ready},  128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {127'b0, in_ready}, 128'd1);

    send(64'h1F, 64'hC, 1'b0, 1'b0);
    send('1, '0, 1'b1, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_idle();

    // Stall the consumer while a second request waits.
    stall = 5;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
    chk("accept_after_hs", 128'(acc_cyc - hs_cyc), 128'd2);
    wait_idle();

    // Reset after two RUN words.
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {127'b0, in_ready}, 128'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("mid_rst_sum",       {64'b0, sum},        128'd0);
    sb.delete();
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_after", {127'b0, in_ready}, 128'd1);
    send(64'd3, 64'd4, 1'b0, 1'b0);
    wait_idle();

    send(64'd5, 64'd7, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      send(pick(), pick(), 1'($urandom), 1'($urandom));
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
